// File: rtl/alu_arbiter.sv
// alu_arbiter: two-requester arbiter feeding a shared 32-bit ALU through a
// two-stage issue/response pipeline. Stage 1 holds the granted operation and
// drives the ALU; stage 2 registers the result and its requester ID.
// Optional feature macro: ALU_ARB_RR_EN. When it is defined, conflicts are
// resolved round-robin. When it is undefined, requester 0 has fixed priority.

module alu (
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  input  logic [3:0]  i_op,
  output logic [31:0] o_result
);

  typedef enum logic [3:0] {
    OP_ADD  = 4'b0000,
    OP_SLL  = 4'b0001,
    OP_SLT  = 4'b0010,
    OP_SLTU = 4'b0011,
    OP_XOR  = 4'b0100,
    OP_SRL  = 4'b0101,
    OP_OR   = 4'b0110,
    OP_AND  = 4'b0111,
    OP_SUB  = 4'b1000,
    OP_SRA  = 4'b1101,
    OP_PASS = 4'b1111
  } alu_op_e;

  logic [4:0] shamt;

  // Combinational ALU; any unlisted op code yields zero.
  always_comb begin
    o_result = '0;
    shamt    = i_b[4:0];
    case (alu_op_e'(i_op))
      OP_ADD:  o_result = i_a + i_b;
      OP_SUB:  o_result = i_a - i_b;
      OP_SLT:  o_result = {31'd0, $signed(i_a) < $signed(i_b)};
      OP_SLTU: o_result = {31'd0, i_a < i_b};
      OP_XOR:  o_result = i_a ^ i_b;
      OP_OR:   o_result = i_a | i_b;
      OP_AND:  o_result = i_a & i_b;
      OP_SLL:  o_result = i_a << shamt;
      OP_SRL:  o_result = i_a >> shamt;
      OP_SRA:  o_result = $unsigned($signed(i_a) >>> shamt);
      OP_PASS: o_result = i_b;
      default: o_result = '0;
    endcase
  end

endmodule

module alu_arbiter (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_req0_valid,
  output logic        o_req0_ready,
  input  logic [31:0] i_req0_operand_a,
  input  logic [31:0] i_req0_operand_b,
  input  logic [3:0]  i_req0_alu_op,
  input  logic        i_req1_valid,
  output logic        o_req1_ready,
  input  logic [31:0] i_req1_operand_a,
  input  logic [31:0] i_req1_operand_b,
  input  logic [3:0]  i_req1_alu_op,
  output logic        o_rsp_valid,
  input  logic        i_rsp_ready,
  output logic [31:0] o_rsp_data,
  output logic        o_rsp_id,
  output logic        o_busy
);

  logic        s1_valid_q, s1_valid_d;
  logic        s1_id_q,    s1_id_d;
  logic [31:0] s1_a_q,     s1_a_d;
  logic [31:0] s1_b_q,     s1_b_d;
  logic [3:0]  s1_op_q,    s1_op_d;
  logic        s2_valid_q, s2_valid_d;
  logic        s2_id_q,    s2_id_d;
  logic [31:0] s2_data_q,  s2_data_d;
`ifdef ALU_ARB_RR_EN
  logic        ptr_q,      ptr_d;
`endif

  logic        s2_free, s1_free;
  logic        pick1, grant0, grant1;
  logic [31:0] alu_result;

  alu u_alu (
    .i_a      (s1_a_q),
    .i_b      (s1_b_q),
    .i_op     (s1_op_q),
    .o_result (alu_result)
  );

  // Arbitration, stage advance and next-state computation.
  always_comb begin
    s2_free = !s2_valid_q | i_rsp_ready;
    s1_free = !s1_valid_q | s2_free;

`ifdef ALU_ARB_RR_EN
    pick1 = i_req1_valid & (!i_req0_valid | ptr_q);
`else
    pick1 = i_req1_valid & !i_req0_valid;
`endif
    grant0 = i_req0_valid & !pick1 & s1_free & !i_rst;
    grant1 = pick1 & s1_free & !i_rst;

    s1_valid_d = s1_valid_q;
    s1_id_d    = s1_id_q;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    s1_op_d    = s1_op_q;
    s2_valid_d = s2_valid_q;
    s2_id_d    = s2_id_q;
    s2_data_d  = s2_data_q;
`ifdef ALU_ARB_RR_EN
    ptr_d      = ptr_q;
    if (grant0) ptr_d = 1'b1;
    if (grant1) ptr_d = 1'b0;
`endif

    // S2 keeps its last data when it drains with S1 empty; only valid drops.
    if (s2_free) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_id_d   = s1_id_q;
        s2_data_d = alu_result;
      end
    end

    if (s1_free) begin
      s1_valid_d = grant0 | grant1;
      if (grant1) begin
        s1_id_d = 1'b1;
        s1_a_d  = i_req1_operand_a;
        s1_b_d  = i_req1_operand_b;
        s1_op_d = i_req1_alu_op;
      end else if (grant0) begin
        s1_id_d = 1'b0;
        s1_a_d  = i_req0_operand_a;
        s1_b_d  = i_req0_operand_b;
        s1_op_d = i_req0_alu_op;
      end
    end
  end

  // Pipeline and pointer registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      s1_valid_q <= 1'b0;
      s1_id_q    <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_op_q    <= '0;
      s2_valid_q <= 1'b0;
      s2_id_q    <= 1'b0;
      s2_data_q  <= '0;
`ifdef ALU_ARB_RR_EN
      ptr_q      <= 1'b0;
`endif
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_id_q    <= s1_id_d;
      s1_a_q     <= s1_a_d;
      s1_b_q     <= s1_b_d;
      s1_op_q    <= s1_op_d;
      s2_valid_q <= s2_valid_d;
      s2_id_q    <= s2_id_d;
      s2_data_q  <= s2_data_d;
`ifdef ALU_ARB_RR_EN
      ptr_q      <= ptr_d;
`endif
    end
  end

  assign o_req0_ready = grant0;
  assign o_req1_ready = grant1;
  assign o_rsp_valid  = s2_valid_q;
  assign o_rsp_data   = s2_data_q;
  assign o_rsp_id     = s2_id_q;
  assign o_busy       = s1_valid_q | s2_valid_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed scenarios followed by random
// traffic, all checked against a queue-based model of in-flight operations.

module tb_alu_arbiter;

`ifdef ALU_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        v0, v1, rdy0, rdy1;
  logic [31:0] a0, b0, a1, b1;
  logic [3:0]  op0, op1;
  logic        rsp_valid, rsp_ready, rsp_id, busy;
  logic [31:0] rsp_data;

  always #5 clk = ~clk;

  alu_arbiter dut (
    .i_clk            (clk),
    .i_rst            (rst),
    .i_req0_valid     (v0),
    .o_req0_ready     (rdy0),
    .i_req0_operand_a (a0),
    .i_req0_operand_b (b0),
    .i_req0_alu_op    (op0),
    .i_req1_valid     (v1),
    .o_req1_ready     (rdy1),
    .i_req1_operand_a (a1),
    .i_req1_operand_b (b1),
    .i_req1_alu_op    (op1),
    .o_rsp_valid      (rsp_valid),
    .i_rsp_ready      (rsp_ready),
    .o_rsp_data       (rsp_data),
    .o_rsp_id         (rsp_id),
    .o_busy           (busy)
  );

  typedef struct {
    bit          id;
    logic [31:0] data;
    int unsigned e;
  } exp_t;

  exp_t        q[$];
  int unsigned edge_n = 0;
  bit          ptr = 1'b0;
  int          n_cmp = 0;
  int          n_err = 0;
  bit          m_g0, m_g1, m_pop, m_rst;
  logic [31:0] m_r0, m_r1;

  function automatic logic [31:0] ref_alu(input logic [31:0] a, input logic [31:0] b,
                                          input logic [3:0] op);
    int unsigned sh;
    longint      sa;
    sh = b[4:0];
    sa = longint'($signed(a));
    case (op)
      4'b0000: return a + b;
      4'b1000: return a - b;
      4'b0010: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'b0011: return (a < b) ? 32'd1 : 32'd0;
      4'b0100: return a ^ b;
      4'b0110: return a | b;
      4'b0111: return a & b;
      4'b0001: return a << sh;
      4'b0101: return a >> sh;
      4'b1101: return 32'(sa / (longint'(1) << sh) - ((sa < 0 && (sa % (longint'(1) << sh)) != 0) ? 1 : 0));
      4'b1111: return b;
      default: return 32'd0;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Mid-cycle: check DUT against the model and record what the next edge does.
  task automatic half();
    bit e_rv, s1f, pick1;
    @(negedge clk);
    e_rv  = (q.size() > 0) && (edge_n >= q[0].e + 2);
    s1f   = (q.size() < 2) || rsp_ready;
    pick1 = v1 && (!v0 || (RR && ptr));
    m_g0  = !rst && s1f && v0 && !pick1;
    m_g1  = !rst && s1f && pick1;
    chk("ready0", rdy0, m_g0);
    chk("ready1", rdy1, m_g1);
    chk("rsp_valid", rsp_valid, e_rv);
    chk("busy", busy, q.size() > 0);
    if (e_rv) begin
      chk("rsp_data", rsp_data, q[0].data);
      chk("rsp_id", rsp_id, q[0].id);
    end
    m_pop = e_rv && rsp_ready;
    m_rst = rst;
    m_r0  = ref_alu(a0, b0, op0);
    m_r1  = ref_alu(a1, b1, op1);
  endtask

  // Active edge: apply the recorded pop/push to the model.
  task automatic edge_upd();
    @(posedge clk);
    if (m_rst) begin
      q.delete();
      ptr = 1'b0;
    end else begin
      if (m_pop) void'(q.pop_front());
      if (m_g0) begin q.push_back('{1'b0, m_r0, edge_n}); ptr = 1'b1; end
      if (m_g1) begin q.push_back('{1'b1, m_r1, edge_n}); ptr = 1'b0; end
    end
    edge_n++;
    #1;
  endtask

  task automatic tick();
    half();
    edge_upd();
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    for (int i = 0; i < n; i++) tick();
    rst = 1'b0;
  endtask

  logic [3:0]  t_op[6];
  logic [31:0] t_a[6], t_b[6], t_r[6];
  int          k, pops;
  bit          acc, done;

  initial begin
    rst = 1'b1; v0 = 0; v1 = 0; rsp_ready = 1;
    a0 = '0; b0 = '0; op0 = '0; a1 = '0; b1 = '0; op1 = '0;
    @(posedge clk); #1;
    do_reset(2);
    half();
    chk("reset_data", rsp_data, 32'h0);
    chk("reset_id", rsp_id, 32'h0);
    edge_upd();

    // Single ADD on requester 0: result visible two cycles after handshake.
    v0 = 1; a0 = 32'h7FFF_FFFF; b0 = 32'h1; op0 = 4'b0000;
    half(); chk("single_ready", rdy0, 1'b1); edge_upd();
    v0 = 0;
    half(); chk("single_early", rsp_valid, 1'b0); edge_upd();
    half();
    chk("single_valid", rsp_valid, 1'b1);
    chk("single_data", rsp_data, 32'h8000_0000);
    chk("single_id", rsp_id, 1'b0);
    edge_upd();

    // Op coverage on requester 1.
    t_op[0] = 4'b1000; t_a[0] = 32'd5;         t_b[0] = 32'd7;  t_r[0] = 32'hFFFF_FFFE;
    t_op[1] = 4'b0010; t_a[1] = 32'hFFFF_FFFF; t_b[1] = 32'd1;  t_r[1] = 32'd1;
    t_op[2] = 4'b0011; t_a[2] = 32'hFFFF_FFFF; t_b[2] = 32'd1;  t_r[2] = 32'd0;
    t_op[3] = 4'b1101; t_a[3] = 32'h8000_0000; t_b[3] = 32'h24; t_r[3] = 32'hF800_0000;
    t_op[4] = 4'b1111; t_a[4] = 32'd99;        t_b[4] = 32'h1234; t_r[4] = 32'h1234;
    t_op[5] = 4'b1010; t_a[5] = 32'd3;         t_b[5] = 32'd4;  t_r[5] = 32'd0;
    for (int i = 0; i < 6; i++) begin
      v1 = 1; a1 = t_a[i]; b1 = t_b[i]; op1 = t_op[i];
      half(); chk("op_ready", rdy1, 1'b1); edge_upd();
      v1 = 0;
      tick();
      half();
      chk("op_valid", rsp_valid, 1'b1);
      chk("op_data", rsp_data, t_r[i]);
      chk("op_id", rsp_id, 1'b1);
      edge_upd();
    end

    // Conflict: both requesters valid every cycle.
    do_reset(1);
    v0 = 1; a0 = 32'd1; b0 = 32'd1; op0 = 4'b0000;
    v1 = 1; a1 = 32'd2; b1 = 32'd2; op1 = 4'b0000;
    for (int i = 0; i < 8; i++) begin
      half();
      if (i >= 2) begin
        chk("conf_valid", rsp_valid, 1'b1);
        chk("conf_id", rsp_id, RR ? 32'(i % 2) : 32'd0);
        chk("conf_data", rsp_data, (RR && (i % 2 == 1)) ? 32'd4 : 32'd2);
      end
      edge_upd();
    end
    v0 = 0; v1 = 0;
    tick(); tick();

    // Backpressure: only two operations fit while the consumer stalls.
    do_reset(1);
    rsp_ready = 0; k = 0;
    for (int i = 0; i < 6; i++) begin
      v0 = (k < 4); a0 = 32'(k); b0 = 32'd100; op0 = 4'b0000;
      half(); acc = rdy0; edge_upd();
      if (acc) k++;
    end
    chk("bp_accepted", 32'(k), 32'd2);
    half(); chk("bp_ready_low", rdy0, 1'b0); edge_upd();
    rsp_ready = 1; pops = 0; done = 0;
    for (int i = 0; i < 20 && !done; i++) begin
      v0 = (k < 4); a0 = 32'(k); b0 = 32'd100; op0 = 4'b0000;
      half(); acc = rdy0;
      if (rsp_valid && rsp_ready) pops++;
      edge_upd();
      if (acc) k++;
      done = (k == 4) && (q.size() == 0);
    end
    v0 = 0;
    chk("bp_drained", 32'(pops), 32'd4);

    // Reset with two operations in flight.
    rsp_ready = 0; k = 0;
    for (int i = 0; i < 6 && k < 2; i++) begin
      v0 = 1; a0 = 32'(i); b0 = 32'd7; op0 = 4'b0110;
      half(); acc = rdy0; edge_upd();
      if (acc) k++;
    end
    v0 = 0;
    chk("mid_inflight", 32'(k), 32'd2);
    do_reset(1);
    half();
    chk("mid_rsp_valid", rsp_valid, 1'b0);
    chk("mid_busy", busy, 1'b0);
    edge_upd();
    rsp_ready = 1;
    for (int i = 0; i < 3; i++) tick();
    v1 = 1; a1 = 32'hF0F0_0000; b1 = 32'h0FF0_00FF; op1 = 4'b0100;
    acc = 0;
    for (int i = 0; i < 4 && !acc; i++) begin
      half(); acc = rdy1; edge_upd();
    end
    v1 = 0;
    chk("mid_new_accept", acc, 1'b1);
    acc = 0;
    for (int i = 0; i < 5 && !acc; i++) begin
      half();
      if (rsp_valid) begin
        acc = 1;
        chk("mid_new_id", rsp_id, 1'b1);
        chk("mid_new_data", rsp_data, 32'hFF00_00FF);
      end
      edge_upd();
    end
    chk("mid_new_seen", acc, 1'b1);

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      rst       = ($urandom_range(0, 99) < 2);
      v0        = ($urandom_range(0, 9) < 6);
      v1        = ($urandom_range(0, 9) < 6);
      a0        = $urandom; b0 = $urandom; op0 = 4'($urandom_range(0, 15));
      a1        = $urandom; b1 = $urandom; op1 = 4'($urandom_range(0, 15));
      rsp_ready = ($urandom_range(0, 9) < 7);
      tick();
    end
    rst = 0; v0 = 0; v1 = 0; rsp_ready = 1;
    for (int i = 0; i < 4; i++) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Two-requester arbiter and two-stage issue pipeline that shares one `alu` instance between the integer execute path (requester 0) and a secondary client such as address generation or the branch-compare unit (requester 1). It accepts valid/ready operation requests, grants one per cycle, registers the operands, and drives the shared ALU. It returns each result through a registered valid/ready response port, tagged with the requester ID.

## Interface
- No parameters; datapath fixed at 32 bits, op code 4 bits.
- Clocking: one clock; reset is synchronous and active-high.
- i_clk  in  1  clock, rising-edge.
- i_rst  in  1  synchronous active-high reset.
- i_req0_valid / i_req1_valid  in  1  request present.
- o_req0_ready / o_req1_ready  out  1  request accepted this cycle when valid also high.
- i_req0_operand_a / i_req1_operand_a  in  32  ALU operand A.
- i_req0_operand_b / i_req1_operand_b  in  32  ALU operand B.
- i_req0_alu_op / i_req1_alu_op  in  4  ALU op code.
- o_rsp_valid  out  1  response held in output register.
- i_rsp_ready  in  1  consumer accepts response.
- o_rsp_data  out  32  ALU result.
- o_rsp_id  out  1  originating requester (0/1).
- o_busy  out  1  stage 1 or stage 2 occupied.

## Operation
- ALU op codes:
  - ADD 0000 (a+b), SUB 1000 (a-b).
  - SLT 0010 (signed a<b → 1/0), SLTU 0011 (unsigned a<b → 1/0).
  - XOR 0100, OR 0110, AND 0111.
  - SLL 0001, SRL 0101, SRA 1101; shift amount is b[4:0].
  - PASS 1111 (result = b).
  - Any other code → result 0. Arithmetic wraps modulo 2^32.
- Stage 1 (S1): issue register holding {valid, id, a, b, op}. Its a, b and op drive the shared ALU combinationally.
- Stage 2 (S2): response register holding {valid, id, data}. It captures the ALU output.
- Advance conditions:
  - s2_free = !S2.valid | i_rsp_ready.
  - s1_free = !S1.valid | s2_free.
- Grant:
  - Raised only when s1_free.
  - If exactly one requester is valid, it is granted.
  - If both are valid, the requester named by the priority pointer is granted.
  - o_reqN_ready = s1_free & grantN. The ready of a non-granted requester is 0.
  - Ready may depend combinationally on valid. Requesters must not make valid depend on ready.
- Priority pointer: after each grant, the pointer moves to the other requester.
- Both stages advance in the same cycle when S2 drains and S1 refills; full throughput is 1 op/cycle.
- A request held (valid=1, not ready) must keep its operands stable. The arbiter does not check this.

## Timing
- Reset (i_rst=1 at an edge):
  - S1.valid, S2.valid, o_rsp_valid, o_busy → 0.
  - o_rsp_data → 0; o_rsp_id → 0; pointer → requester 0.
  - In-flight ops are dropped with no response.
  - Ready outputs are 0 while i_rst is high.
- Latency: request accepted at edge N → o_rsp_valid=1 from edge N+1 with result, provided S2 was free at edge N+1. Total: 2 cycles from valid/ready handshake to response-visible... measured as handshake cycle C, response valid in cycle C+2.
- Backpressure:
  - With i_rsp_ready=0, S2 holds o_rsp_data/o_rsp_id stable.
  - S1 fills once more, then both ready outputs drop to 0.
  - Maximum 2 ops in flight.
- Simultaneous pop and push: S2 pops, S1 moves to S2 and S1 refills, all in one cycle. No bubble is inserted.
- No combinational path from i_rsp_ready to o_rsp_* data; o_rsp_* are registered.
- o_busy = S1.valid | S2.valid, combinational from registers.

## Configuration
- ALU_ARB_RR_EN defined: round-robin pointer as described.
- ALU_ARB_RR_EN undefined: fixed priority. Requester 0 always wins a conflict, the pointer register is removed, and requester 1 may starve under continuous requester-0 traffic.

## Test plan
- Reset then single op: req0 ADD a=0x7FFFFFFF, b=1 → 2 cycles later o_rsp_valid=1, data=0x80000000, id=0.
- Op coverage (req1, rsp_ready=1):
  - SUB 5-7 → 0xFFFFFFFE.
  - SLT a=0xFFFFFFFF, b=1 → 1; SLTU with same a, b → 0.
  - SRA a=0x80000000, b=0x24 (amount 4) → 0xF8000000.
  - PASS b=0x1234 → 0x1234; op 1010 → 0.
- Conflict, ALU_ARB_RR_EN defined: both valid continuously with ADD 1+1 (req0) and ADD 2+2 (req1) → responses alternate id 0,1,0,1 with data 2,4,2,4, one per cycle. Without the macro → all responses id 0.
- Backpressure: stream 4 ops with i_rsp_ready=0 → exactly 2 accepted, readies drop to 0, o_rsp_data stable. Raise rsp_ready → remaining ops drain in order with no loss or duplication.
- Reset mid-operation: 2 ops in flight, assert i_rst for 1 cycle → o_rsp_valid=0, o_busy=0, and no stale response appears afterwards. A new req1 op then completes normally with id=1.
